// File: rtl/plus_args_tx.sv
// plus_args_tx
// Streams a simulator plus-argument set as ASCII bytes over a valid/ready
// byte interface. One accepted start emits either
//   "+USER_MODE" NEWLINE "+TEST=" HH NEWLINE   (captured user_mode = 1, 20 bytes)
// or
//   "+TEST=" HH NEWLINE                         (captured user_mode = 0, 9 bytes)
// where HH is the captured test_id as two uppercase hex digits.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      frame request, sampled only while busy = 0
//   user_mode  selects the "+USER_MODE" line (captured on start)
//   test_id    test number, emitted in hex (captured on start)
//   tx_data    current ASCII byte
//   tx_valid   tx_data holds a byte to transfer
//   tx_ready   sink accepts; a transfer is tx_valid & tx_ready at a rising edge
//   busy       high from the cycle after start is accepted until the last transfer
//   done       one-cycle pulse in the cycle after the final transfer
module plus_args_tx #(
    parameter logic [7:0] NEWLINE = 8'h0A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       user_mode,
    input  logic [7:0] test_id,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        UMODE = 3'd1,
        THDR  = 3'd2,
        HEXH  = 3'd3,
        HEXL  = 3'd4,
        TERM  = 3'd5
    } state_t;

    // Last index of each multi-byte state; the UMODE string carries its own
    // NEWLINE as byte 10.
    localparam logic [3:0] UMODE_LAST = 4'd10;
    localparam logic [3:0] THDR_LAST  = 4'd5;

    state_t     state_reg, state_next;
    logic [3:0] idx_reg, idx_next;
    logic       done_reg, done_next;
    logic       user_mode_reg;
    logic [7:0] test_id_reg;

    logic xfer;
    logic accept;

    assign xfer   = tx_valid & tx_ready;
    assign accept = start & (state_reg == IDLE);

    // "+USER_MODE" followed by NEWLINE
    function automatic logic [7:0] umode_char(input logic [3:0] i);
        case (i)
            4'd0:    umode_char = 8'h2B; // +
            4'd1:    umode_char = 8'h55; // U
            4'd2:    umode_char = 8'h53; // S
            4'd3:    umode_char = 8'h45; // E
            4'd4:    umode_char = 8'h52; // R
            4'd5:    umode_char = 8'h5F; // _
            4'd6:    umode_char = 8'h4D; // M
            4'd7:    umode_char = 8'h4F; // O
            4'd8:    umode_char = 8'h44; // D
            4'd9:    umode_char = 8'h45; // E
            default: umode_char = NEWLINE;
        endcase
    endfunction

    // "+TEST="
    function automatic logic [7:0] thdr_char(input logic [3:0] i);
        case (i)
            4'd0:    thdr_char = 8'h2B; // +
            4'd1:    thdr_char = 8'h54; // T
            4'd2:    thdr_char = 8'h45; // E
            4'd3:    thdr_char = 8'h53; // S
            4'd4:    thdr_char = 8'h54; // T
            default: thdr_char = 8'h3D; // =
        endcase
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            hex_char = 8'h30 + {4'h0, n};
        end else begin
            hex_char = 8'h37 + {4'h0, n};
        end
    endfunction

    // State register, byte index, done pulse and captured fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= 4'd0;
            done_reg      <= 1'b0;
            user_mode_reg <= 1'b0;
            test_id_reg   <= 8'h00;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            done_reg  <= done_next;
            if (accept) begin
                user_mode_reg <= user_mode;
                test_id_reg   <= test_id;
            end
        end
    end

    // Next-state logic; every state entry clears the byte index
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = user_mode ? UMODE : THDR;
                    idx_next   = 4'd0;
                end
            end
            UMODE: begin
                if (xfer) begin
                    if (idx_reg == UMODE_LAST) begin
                        state_next = THDR;
                        idx_next   = 4'd0;
                    end else begin
                        idx_next = idx_reg + 4'd1;
                    end
                end
            end
            THDR: begin
                if (xfer) begin
                    if (idx_reg == THDR_LAST) begin
                        state_next = HEXH;
                        idx_next   = 4'd0;
                    end else begin
                        idx_next = idx_reg + 4'd1;
                    end
                end
            end
            HEXH: begin
                if (xfer) begin
                    state_next = HEXL;
                    idx_next   = 4'd0;
                end
            end
            HEXL: begin
                if (xfer) begin
                    state_next = TERM;
                    idx_next   = 4'd0;
                end
            end
            TERM: begin
                if (xfer) begin
                    state_next = IDLE;
                    idx_next   = 4'd0;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = 4'd0;
            end
        endcase
    end

    // Outputs depend only on registered state, so tx_data cannot move while
    // the sink stalls.
    always_comb begin
        tx_valid = (state_reg != IDLE);
        busy     = (state_reg != IDLE);
        done     = done_reg;
        case (state_reg)
            UMODE:   tx_data = umode_char(idx_reg);
            THDR:    tx_data = thdr_char(idx_reg);
            HEXH:    tx_data = hex_char(test_id_reg[7:4]);
            HEXL:    tx_data = hex_char(test_id_reg[3:0]);
            TERM:    tx_data = NEWLINE;
            default: tx_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_plus_args_tx.sv
module tb_plus_args_tx;

    typedef logic [7:0] byte_q_t[$];

    localparam logic [7:0] NL = 8'h0A;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       user_mode = 1'b0;
    logic [7:0] test_id = 8'h00;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;

    plus_args_tx #(.NEWLINE(NL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .user_mode (user_mode),
        .test_id   (test_id),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference: the frame text built directly from its textual definition
    function automatic logic [7:0] hex_digit(input logic [3:0] n);
        logic [7:0] zero_c;
        logic [7:0] a_c;
        zero_c = "0";
        a_c    = "A";
        if (n <= 4'd9) return zero_c + 8'(n);
        return a_c + 8'(n) - 8'd10;
    endfunction

    function automatic void build_expected(input logic um, input logic [7:0] id,
                                           output byte_q_t q);
        string s;
        q = {};
        if (um) begin
            s = "+USER_MODE";
            for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
            q.push_back(NL);
        end
        s = "+TEST=";
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        q.push_back(hex_digit(id[7:4]));
        q.push_back(hex_digit(id[3:0]));
        q.push_back(NL);
    endfunction

    // Called right after a falling edge: requests a frame, returns at the
    // falling edge of the first cycle after acceptance.
    task automatic start_frame(input logic um, input logic [7:0] id);
        start     = 1'b1;
        user_mode = um;
        test_id   = id;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives tx_ready and records transferred bytes until done is seen.
    // Cycle 1 is the first cycle after start acceptance.
    task automatic collect(input int ready_pct, input bit disturb, input int max_cycles,
                           output byte_q_t got, output int busy_cycles,
                           output int done_cycle, output int stall_err,
                           output bit timed_out);
        bit         prev_stall;
        logic [7:0] prev_data;
        bit         rdy;
        bit         finished;
        got         = {};
        busy_cycles = 0;
        done_cycle  = -1;
        stall_err   = 0;
        prev_stall  = 1'b0;
        prev_data   = 8'h00;
        finished    = 1'b0;
        for (int c = 1; c <= max_cycles && !finished; c++) begin
            if (done === 1'b1) begin
                done_cycle = c;
                start      = 1'b0;
                finished   = 1'b1;
            end else begin
                if (busy === 1'b1) busy_cycles++;
                if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) stall_err++;
                rdy        = ($urandom_range(99) < ready_pct);
                tx_ready   = rdy;
                prev_stall = (tx_valid === 1'b1) && !rdy;
                prev_data  = tx_data;
                if (tx_valid === 1'b1 && rdy) got.push_back(tx_data);
                if (disturb) begin
                    start     = $urandom_range(1);
                    user_mode = $urandom_range(1);
                    test_id   = 8'($urandom);
                end
                @(negedge clk);
            end
        end
        timed_out = !finished;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: outputs idle");
    endtask

    task automatic test_basic();
        byte_q_t exp, got;
        int bc, dc, se;
        bit to;
        build_expected(1'b0, 8'h3A, exp);
        @(negedge clk);
        start_frame(1'b0, 8'h3A);
        collect(100, 1'b0, 200, got, bc, dc, se, to);
        checks++;
        if (to) begin failures++; $display("FAIL basic_timeout got=timeout exp=done"); end
        checks++;
        if (got.size() != exp.size()) begin failures++; $display("FAIL basic_len got=%0d exp=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                failures++;
                $display("FAIL basic_byte[%0d] got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
            end
        end
        checks++;
        if (dc != 10) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=10", dc); end
        checks++;
        if (bc != 9) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=9", bc); end
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_idle got=valid%b/busy%b exp=valid0/busy0", tx_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL basic_done_width got=%b exp=0", done); end
        $display("basic: um=0 id=3A bytes=%0d done_cycle=%0d", got.size(), dc);
    endtask

    task automatic test_user_mode();
        byte_q_t exp, got;
        int bc, dc, se;
        bit to;
        build_expected(1'b1, 8'h05, exp);
        @(negedge clk);
        start_frame(1'b1, 8'h05);
        collect(100, 1'b0, 200, got, bc, dc, se, to);
        checks++;
        if (to) begin failures++; $display("FAIL umode_timeout got=timeout exp=done"); end
        checks++;
        if (got.size() != 20) begin failures++; $display("FAIL umode_len got=%0d exp=20", got.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                failures++;
                $display("FAIL umode_byte[%0d] got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
            end
        end
        checks++;
        if (bc != 20) begin failures++; $display("FAIL umode_busy_cycles got=%0d exp=20", bc); end
        checks++;
        if (dc != 21) begin failures++; $display("FAIL umode_done_cycle got=%0d exp=21", dc); end
        $display("user_mode: um=1 id=05 bytes=%0d busy_cycles=%0d", got.size(), bc);
    endtask

    task automatic test_random_frames(input int ready_pct, input int n);
        byte_q_t exp, got;
        int bc, dc, se;
        bit to;
        logic um;
        logic [7:0] id;
        for (int f = 0; f < n; f++) begin
            um = $urandom_range(1);
            id = 8'($urandom);
            build_expected(um, id, exp);
            @(negedge clk);
            start_frame(um, id);
            collect(ready_pct, 1'b0, 400, got, bc, dc, se, to);
            checks++;
            if (to) begin failures++; $display("FAIL rand_timeout frame=%0d got=timeout exp=done", f); end
            checks++;
            if (got.size() != exp.size()) begin failures++; $display("FAIL rand_len frame=%0d got=%0d exp=%0d", f, got.size(), exp.size()); end
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (i >= got.size() || got[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL rand_byte frame=%0d [%0d] got=%h exp=%h", f, i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
                end
            end
            checks++;
            if (se != 0) begin failures++; $display("FAIL rand_stall_stable frame=%0d got=%0d exp=0", f, se); end
            if (ready_pct == 100) begin
                checks++;
                if (bc != exp.size()) begin failures++; $display("FAIL rand_busy_cycles frame=%0d got=%0d exp=%0d", f, bc, exp.size()); end
            end
            $display("random: ready=%0d%% um=%0d id=%h bytes=%0d busy_cycles=%0d", ready_pct, um, id, got.size(), bc);
        end
    endtask

    task automatic test_ignore_start();
        byte_q_t exp, got;
        int bc, dc, se;
        bit to;
        logic um;
        logic [7:0] id;
        for (int f = 0; f < 3; f++) begin
            um = $urandom_range(1);
            id = 8'($urandom);
            build_expected(um, id, exp);
            @(negedge clk);
            start_frame(um, id);
            collect(70, 1'b1, 400, got, bc, dc, se, to);
            checks++;
            if (to) begin failures++; $display("FAIL ignore_timeout frame=%0d got=timeout exp=done", f); end
            checks++;
            if (got.size() != exp.size()) begin failures++; $display("FAIL ignore_len frame=%0d got=%0d exp=%0d", f, got.size(), exp.size()); end
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (i >= got.size() || got[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL ignore_byte frame=%0d [%0d] got=%h exp=%h", f, i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
                end
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin failures++; $display("FAIL ignore_no_restart frame=%0d got=%b exp=0", f, busy); end
            $display("ignore_start: um=%0d id=%h bytes=%0d", um, id, got.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        byte_q_t exp, got;
        int bc, dc, se;
        bit to;
        logic [7:0] id;
        id = 8'($urandom);
        build_expected(1'b1, id, exp);
        @(negedge clk);
        start_frame(1'b1, id);
        tx_ready = 1'b1;
        for (int c = 1; c < 5; c++) @(negedge clk);
        checks++;
        if (tx_data !== exp[4]) begin failures++; $display("FAIL midrst_pre_byte got=%h exp=%h", tx_data, exp[4]); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_data !== 8'h00 || tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async got=data%h/valid%b/busy%b/done%b exp=data00/valid0/busy0/done0",
                     tx_data, tx_valid, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_resume got=%b exp=0", tx_valid); end
        build_expected(1'b0, 8'hFF, exp);
        @(negedge clk);
        start_frame(1'b0, 8'hFF);
        collect(100, 1'b0, 200, got, bc, dc, se, to);
        checks++;
        if (to) begin failures++; $display("FAIL midrst_timeout got=timeout exp=done"); end
        checks++;
        if (got.size() != exp.size()) begin failures++; $display("FAIL midrst_len got=%0d exp=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                failures++;
                $display("FAIL midrst_byte[%0d] got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
            end
        end
        $display("reset_mid_frame: aborted id=%h, restart id=FF bytes=%0d", id, got.size());
    endtask

    task automatic test_back_to_back();
        byte_q_t exp_a, exp_b, got_a, got_b;
        int bc, dc, se;
        bit to_a, to_b;
        logic um_a, um_b;
        logic [7:0] id_a, id_b;
        um_a = $urandom_range(1);
        id_a = 8'($urandom);
        um_b = $urandom_range(1);
        id_b = 8'($urandom);
        build_expected(um_a, id_a, exp_a);
        build_expected(um_b, id_b, exp_b);
        @(negedge clk);
        start_frame(um_a, id_a);
        collect(100, 1'b0, 200, got_a, bc, dc, se, to_a);
        // Still in the done cycle: request the next frame immediately
        start_frame(um_b, id_b);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== exp_b[0]) begin
            failures++;
            $display("FAIL b2b_first got=valid%b/data%h exp=valid1/data%h", tx_valid, tx_data, exp_b[0]);
        end
        collect(100, 1'b0, 200, got_b, bc, dc, se, to_b);
        checks++;
        if (to_a || to_b) begin failures++; $display("FAIL b2b_timeout got=timeout exp=done"); end
        checks++;
        if (got_a.size() != exp_a.size() || got_b.size() != exp_b.size()) begin
            failures++;
            $display("FAIL b2b_len got=%0d/%0d exp=%0d/%0d", got_a.size(), got_b.size(), exp_a.size(), exp_b.size());
        end
        for (int i = 0; i < exp_a.size(); i++) begin
            checks++;
            if (i >= got_a.size() || got_a[i] !== exp_a[i]) begin
                failures++;
                $display("FAIL b2b_a_byte[%0d] got=%h exp=%h", i, (i < got_a.size()) ? got_a[i] : 8'hxx, exp_a[i]);
            end
        end
        for (int i = 0; i < exp_b.size(); i++) begin
            checks++;
            if (i >= got_b.size() || got_b[i] !== exp_b[i]) begin
                failures++;
                $display("FAIL b2b_b_byte[%0d] got=%h exp=%h", i, (i < got_b.size()) ? got_b[i] : 8'hxx, exp_b[i]);
            end
        end
        checks++;
        if (bc != exp_b.size()) begin failures++; $display("FAIL b2b_busy_cycles got=%0d exp=%0d", bc, exp_b.size()); end
        $display("back_to_back: a(um=%0d id=%h) b(um=%0d id=%h) bytes=%0d+%0d",
                 um_a, id_a, um_b, id_b, got_a.size(), got_b.size());
    endtask

    initial begin
        test_reset();
        test_basic();
        test_user_mode();
        test_random_frames(100, 6);
        test_random_frames(50, 6);
        test_ignore_start();
        test_reset_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/plus_args_tx.md
PLUS_ARGS_TX -- requirements
Module: plus_args_tx

Interface
REQ-001 SHALL have parameter NEWLINE, default 8'h0A, terminator byte appended to every argument string.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request to emit one argument set; sampled only while busy=0.
REQ-005 SHALL have port user_mode  input  1  when 1, the "+USER_MODE" string is emitted.
REQ-006 SHALL have port test_id  input  8  test number, emitted as two uppercase ASCII hex digits.
REQ-007 SHALL have port tx_data  output  8  current ASCII byte.
REQ-008 SHALL have port tx_valid  output  1  tx_data holds a byte to transfer.
REQ-009 SHALL have port tx_ready  input  1  sink accepts byte; transfer = tx_valid & tx_ready at rising edge.
REQ-010 SHALL have port busy  output  1  high from the cycle after start is accepted until the last byte transfers.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the last byte transfers.

Function
REQ-012 SHALL capture user_mode and test_id on the edge where start=1 and busy=0; later input changes SHALL NOT affect the frame in progress.
REQ-013 SHALL ignore start while busy=1 (no queuing, no restart).
REQ-014 SHALL emit, when captured user_mode=1, bytes "+USER_MODE" then NEWLINE (11 bytes), followed by the TEST string.
REQ-015 SHALL emit the TEST string "+TEST=", hex-high, hex-low, NEWLINE (9 bytes); total frame is 20 bytes with user_mode=1, 9 bytes without.
REQ-016 SHALL encode nibble n as 8'h30+n for n<10 and 8'h37+n for n>=10 (uppercase 'A'-'F').
REQ-017 SHALL implement FSM states IDLE, UMODE, THDR, HEXH, HEXL, TERM; IDLE->UMODE or THDR on accepted start; UMODE->THDR after its NEWLINE; THDR->HEXH->HEXL->TERM, each step on transfer; TERM->IDLE on transfer.
REQ-018 SHALL assert tx_valid and busy, with the first byte on tx_data, in the cycle after start is accepted (latency 1).
REQ-019 SHALL hold tx_data stable and tx_valid high while tx_ready=0 (no byte dropped, none withdrawn).
REQ-020 SHALL present the next byte in the cycle after each transfer with no bubble, sustaining one byte per cycle under continuous tx_ready=1.
REQ-021 SHALL, in the cycle after the final NEWLINE transfer, drive tx_valid=0, busy=0, done=1; done SHALL be 0 in every other cycle.
REQ-022 SHALL accept a new start in the same cycle done=1 (back-to-back frames, one-cycle gap minimum).
REQ-023 SHALL use a byte index counter that resets to 0 on every state entry and never exceeds string length minus 1.

Reset
REQ-024 SHALL, while rst_n=0, force state IDLE, tx_data=8'h00, tx_valid=0, busy=0, done=0, counters and captured fields to 0.
REQ-025 SHALL abort any frame in progress on rst_n assertion mid-frame; after release no partial frame resumes and the next start emits a full frame.

Verification
REQ-026 SHALL test: start, user_mode=0, test_id=8'h3A, tx_ready=1 -> bytes 2B 54 45 53 54 3D 33 41 0A in 9 consecutive cycles, done on cycle 10.
REQ-027 SHALL test: start, user_mode=1, test_id=8'h05 -> 20 bytes "+USER_MODE\n+TEST=05\n", busy high exactly 20 cycles.
REQ-028 SHALL test: random tx_ready backpressure (~50%) -> identical byte sequence, tx_data stable whenever tx_valid=1 and tx_ready=0.
REQ-029 SHALL test: start pulsed and user_mode/test_id changed while busy -> ignored; frame matches captured values.
REQ-030 SHALL test: rst_n low at byte 5 of a 20-byte frame -> outputs zero immediately (asynchronous); subsequent start with test_id=8'hFF -> "+TEST=FF\n".
REQ-031 SHALL test: start asserted in the done cycle -> second frame begins next cycle with no lost or duplicated bytes.
